// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM burst-to-stream reader.
// Only the FSM encoding lives here; data and address widths stay module parameters.
package bram_stream_reader_pkg;

    localparam int unsigned StateWidth = 2;

    typedef enum logic [StateWidth-1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2
    } state_e;

endpackage

// File: rtl/bram_stream_reader.sv
// Reads a burst of words from a credit-based BRAM read port and presents them
// as a stream through a one-entry output register, with a DONE pulse at the end.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int unsigned addr_width = 1,
    parameter int unsigned data_width = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [addr_width-1:0] CMD_START,
    input  logic [addr_width:0]   CMD_LEN,
    input  logic                  CMD_EN,
    output logic                  CMD_RDY,
    output logic [addr_width-1:0] MEM_RD_ADDR,
    output logic                  MEM_RD_EN,
    input  logic                  MEM_RD_RDY,
    input  logic [data_width-1:0] MEM_DOUT,
    input  logic                  MEM_DOUT_RDY,
    output logic                  MEM_DOUT_EN,
    output logic [data_width-1:0] OUT_DATA,
    output logic                  OUT_LAST,
    output logic                  OUT_RDY,
    input  logic                  OUT_EN,
    output logic                  DONE
);

    localparam logic [addr_width:0] CntOne = (addr_width + 1)'(1);

    state_e                state_q, state_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [addr_width:0]   iss_left_q, iss_left_d;
    logic [addr_width:0]   rcv_left_q, rcv_left_d;
    logic                  done_q, done_d;
    logic [data_width-1:0] out_data_q;
    logic                  out_last_q;
    logic                  out_rdy_q;

    logic busy;
    logic rd_fire;
    logic dout_fire;
    logic last_deq;

    assign busy      = (state_q != StIdle);
    assign rd_fire   = (state_q == StIssue) && MEM_RD_RDY;
    // The output register may refill in the same cycle it is being emptied.
    assign dout_fire = MEM_DOUT_RDY && busy && (!out_rdy_q || OUT_EN);
    assign last_deq  = (state_q == StDrain) && (rcv_left_q == '0) && out_rdy_q
                       && out_last_q && OUT_EN;

    assign CMD_RDY     = (state_q == StIdle);
    assign MEM_RD_EN   = rd_fire;
    assign MEM_RD_ADDR = addr_q;
    assign MEM_DOUT_EN = dout_fire;
    assign OUT_DATA    = out_data_q;
    assign OUT_LAST    = out_last_q;
    assign OUT_RDY     = out_rdy_q;
    assign DONE        = done_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        iss_left_d = iss_left_q;
        rcv_left_d = rcv_left_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (CMD_EN) begin
                    addr_d     = CMD_START;
                    iss_left_d = CMD_LEN;
                    rcv_left_d = CMD_LEN;
                    if (CMD_LEN == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (rd_fire) begin
                    addr_d     = addr_q + 1'b1;
                    iss_left_d = iss_left_q - 1'b1;
                    if (iss_left_q == CntOne) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (last_deq) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Never fires in StIdle, so it cannot collide with the command load.
        if (dout_fire) begin
            rcv_left_d = rcv_left_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            iss_left_q <= '0;
            rcv_left_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            iss_left_q <= iss_left_d;
            rcv_left_q <= rcv_left_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_rdy_q  <= 1'b0;
        end else if (dout_fire) begin
            out_data_q <= MEM_DOUT;
            out_last_q <= (rcv_left_q == CntOne);
            out_rdy_q  <= 1'b1;
        end else if (OUT_EN) begin
            out_rdy_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader paired with a 2-credit BRAM model preloaded with
// arr[i] = i + 0x100; bursts are checked against a word list computed from the command.
module tb_bram_stream_reader;

    localparam int unsigned Aw = 4;
    localparam int unsigned Dw = 16;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [Aw-1:0] cmd_start;
    logic [Aw:0]   cmd_len;
    logic          cmd_en;
    logic          CMD_RDY;
    logic [Aw-1:0] MEM_RD_ADDR;
    logic          MEM_RD_EN;
    logic          MEM_RD_RDY;
    logic [Dw-1:0] MEM_DOUT;
    logic          MEM_DOUT_RDY;
    logic          MEM_DOUT_EN;
    logic [Dw-1:0] OUT_DATA;
    logic          OUT_LAST;
    logic          OUT_RDY;
    logic          OUT_EN;
    logic          DONE;
    logic          oe_mask;

    int vec  = 0;
    int miss = 0;

    always #5 CLK = ~CLK;

    assign OUT_EN = oe_mask & OUT_RDY;

    bram_stream_reader #(
        .addr_width(Aw),
        .data_width(Dw)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .CMD_START   (cmd_start),
        .CMD_LEN     (cmd_len),
        .CMD_EN      (cmd_en),
        .CMD_RDY     (CMD_RDY),
        .MEM_RD_ADDR (MEM_RD_ADDR),
        .MEM_RD_EN   (MEM_RD_EN),
        .MEM_RD_RDY  (MEM_RD_RDY),
        .MEM_DOUT    (MEM_DOUT),
        .MEM_DOUT_RDY(MEM_DOUT_RDY),
        .MEM_DOUT_EN (MEM_DOUT_EN),
        .OUT_DATA    (OUT_DATA),
        .OUT_LAST    (OUT_LAST),
        .OUT_RDY     (OUT_RDY),
        .OUT_EN      (OUT_EN),
        .DONE        (DONE)
    );

    // BRAM model: up to two requests in flight, responses in order.
    logic [Dw-1:0] mem [16];
    logic [Dw-1:0] mq  [2];
    int            mcnt;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h100 + 16'(i);
    end

    assign MEM_RD_RDY   = (mcnt < 2);
    assign MEM_DOUT_RDY = (mcnt != 0);
    assign MEM_DOUT     = mq[0];

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mcnt <= 0;
        end else begin
            case ({MEM_RD_EN && MEM_RD_RDY, MEM_DOUT_EN && MEM_DOUT_RDY})
                2'b10: begin
                    mq[mcnt] <= mem[MEM_RD_ADDR];
                    mcnt     <= mcnt + 1;
                end
                2'b01: begin
                    mq[0] <= mq[1];
                    mcnt  <= mcnt - 1;
                end
                2'b11: begin
                    if (mcnt == 1) begin
                        mq[0] <= mem[MEM_RD_ADDR];
                    end else begin
                        mq[0] <= mq[1];
                        mq[1] <= mem[MEM_RD_ADDR];
                    end
                end
                default: ;
            endcase
        end
    end

    // Observation away from the active edge.
    logic [Dw-1:0] got_data [$];
    bit            got_last [$];
    logic [Aw-1:0] got_addr [$];
    int            done_cnt      = 0;
    int            done_ok_cnt   = 0;
    int            viol          = 0;
    int            outstanding   = 0;
    int            max_out       = 0;
    bit            last_deq_prev = 0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            outstanding   = 0;
            last_deq_prev = 0;
        end else begin
            if (MEM_RD_EN && !MEM_RD_RDY) viol++;
            if (MEM_RD_EN && CMD_RDY) viol++;
            if (MEM_DOUT_EN && (CMD_RDY || !MEM_DOUT_RDY)) viol++;
            if (MEM_RD_EN && MEM_RD_RDY) begin
                got_addr.push_back(MEM_RD_ADDR);
                outstanding++;
            end
            if (MEM_DOUT_EN) outstanding--;
            if (outstanding > max_out) max_out = outstanding;
            if (DONE) begin
                done_cnt++;
                if (!CMD_RDY) viol++;
                if (last_deq_prev) done_ok_cnt++;
            end
            last_deq_prev = OUT_RDY && OUT_EN && OUT_LAST;
            if (OUT_RDY && OUT_EN) begin
                got_data.push_back(OUT_DATA);
                got_last.push_back(OUT_LAST);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // mode 0: OUT_EN tied high; 1: random OUT_EN; 2: 10-cycle stall after stall_at words.
    task automatic run_burst(input logic [Aw-1:0] start, input int len, input int mode,
                             input int stall_at, input bit poke, input string name);
        int            b_d    = got_data.size();
        int            b_a    = got_addr.size();
        int            b_done = done_cnt;
        int            b_ok   = done_ok_cnt;
        int            b_viol = viol;
        int            cyc    = 0;
        int            stall_rem = 0;
        bit            stalled = 0;
        logic [Dw-1:0] exp_d;
        logic [Aw-1:0] exp_a;
        max_out   = 0;
        oe_mask   = 1'b1;
        tick();
        cmd_start = start;
        cmd_len   = (Aw + 1)'(len);
        cmd_en    = 1'b1;
        tick();
        cmd_en    = 1'b0;
        cmd_start = Aw'($urandom);
        cmd_len   = (Aw + 1)'($urandom);
        while (done_cnt == b_done && cyc < 600) begin
            if (mode == 1) oe_mask = 1'($urandom);
            if (mode == 2) begin
                if (!stalled && (got_data.size() - b_d) >= stall_at) begin
                    stalled   = 1;
                    stall_rem = 10;
                end
                oe_mask = (stall_rem == 0);
                if (stall_rem > 0) stall_rem--;
            end
            if (poke && cyc == 2) begin
                vec++;
                if (CMD_RDY !== 1'b0) begin
                    miss++;
                    $display("FAIL %s cmd_rdy_busy: got %b expected 0", name, CMD_RDY);
                end
                cmd_en    = 1'b1;
                cmd_start = '0;
                cmd_len   = 3;
            end else begin
                cmd_en = 1'b0;
            end
            tick();
            cyc++;
        end
        cmd_en  = 1'b0;
        oe_mask = 1'b1;
        vec++;
        if (cyc >= 600) begin
            miss++;
            $display("FAIL %s timeout: no DONE after %0d cycles", name, cyc);
        end
        repeat (3) tick();

        vec++;
        if (got_data.size() - b_d != len) begin
            miss++;
            $display("FAIL %s word_count: got %0d expected %0d", name, got_data.size() - b_d, len);
        end
        vec++;
        if (got_addr.size() - b_a != len) begin
            miss++;
            $display("FAIL %s req_count: got %0d expected %0d", name, got_addr.size() - b_a, len);
        end
        for (int i = 0; i < len; i++) begin
            exp_a = Aw'((int'(start) + i) % 16);
            exp_d = mem[exp_a];
            if (b_d + i < got_data.size()) begin
                vec++;
                if (got_data[b_d + i] !== exp_d) begin
                    miss++;
                    $display("FAIL %s data[%0d]: got %h expected %h", name, i,
                             got_data[b_d + i], exp_d);
                end
                vec++;
                if (got_last[b_d + i] !== (i == len - 1)) begin
                    miss++;
                    $display("FAIL %s last[%0d]: got %b expected %b", name, i,
                             got_last[b_d + i], (i == len - 1));
                end
            end
            if (b_a + i < got_addr.size()) begin
                vec++;
                if (got_addr[b_a + i] !== exp_a) begin
                    miss++;
                    $display("FAIL %s addr[%0d]: got %0d expected %0d", name, i,
                             got_addr[b_a + i], exp_a);
                end
            end
        end
        vec++;
        if (done_cnt - b_done != 1) begin
            miss++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - b_done);
        end
        vec++;
        if (done_ok_cnt - b_ok != 1) begin
            miss++;
            $display("FAIL %s done_timing: got %0d expected 1", name, done_ok_cnt - b_ok);
        end
        vec++;
        if (viol != b_viol) begin
            miss++;
            $display("FAIL %s protocol: got %0d violations expected 0", name, viol - b_viol);
        end
        vec++;
        if (max_out > 2) begin
            miss++;
            $display("FAIL %s outstanding: got %0d expected <=2", name, max_out);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vec++;
        if ({OUT_RDY, OUT_LAST, DONE, MEM_RD_EN, MEM_DOUT_EN, CMD_RDY} !== 6'b000001) begin
            miss++;
            $display("FAIL %s flags: got %b expected 000001", name,
                     {OUT_RDY, OUT_LAST, DONE, MEM_RD_EN, MEM_DOUT_EN, CMD_RDY});
        end
        vec++;
        if (OUT_DATA !== '0) begin
            miss++;
            $display("FAIL %s out_data: got %h expected 0000", name, OUT_DATA);
        end
    endtask

    task automatic test_reset();
        RST_N     = 1'b0;
        cmd_en    = 1'b0;
        cmd_start = '0;
        cmd_len   = '0;
        oe_mask   = 1'b1;
        #12;
        check_reset_outputs("reset");
        tick();
        RST_N = 1'b1;
        tick();
        check_reset_outputs("post_reset");
    endtask

    task automatic test_len_zero();
        int b_a = got_addr.size();
        tick();
        cmd_start = 4'd7;
        cmd_len   = '0;
        cmd_en    = 1'b1;
        tick();
        cmd_en = 1'b0;
        vec++;
        if (DONE !== 1'b1 || CMD_RDY !== 1'b1) begin
            miss++;
            $display("FAIL len0_done: got done=%b rdy=%b expected 1 1", DONE, CMD_RDY);
        end
        tick();
        vec++;
        if (DONE !== 1'b0 || CMD_RDY !== 1'b1) begin
            miss++;
            $display("FAIL len0_after: got done=%b rdy=%b expected 0 1", DONE, CMD_RDY);
        end
        repeat (3) tick();
        vec++;
        if (got_addr.size() != b_a) begin
            miss++;
            $display("FAIL len0_reqs: got %0d expected 0", got_addr.size() - b_a);
        end
    endtask

    task automatic test_reset_mid_burst();
        int b_d = got_data.size();
        int cyc = 0;
        tick();
        cmd_start = 4'd2;
        cmd_len   = 5'd8;
        cmd_en    = 1'b1;
        tick();
        cmd_en = 1'b0;
        while ((got_data.size() - b_d) < 3 && cyc < 200) begin
            tick();
            cyc++;
        end
        vec++;
        if (cyc >= 200) begin
            miss++;
            $display("FAIL rst_mid_wait: got %0d words expected 3", got_data.size() - b_d);
        end
        RST_N = 1'b0;
        #2;
        check_reset_outputs("rst_mid");
        tick();
        RST_N = 1'b1;
        tick();
        run_burst(4'd9, 2, 0, 0, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        run_burst(4'd4, 8, 0, 0, 1'b0, "basic");
        test_len_zero();
        run_burst(4'd14, 4, 0, 0, 1'b0, "wrap");
        run_burst(4'd1, 12, 2, 4, 1'b0, "stall");
        test_reset_mid_burst();
        run_burst(4'd3, 8, 0, 0, 1'b1, "cmd_ignored");
        for (int k = 0; k < 6; k++) begin
            run_burst(Aw'($urandom), int'($urandom_range(1, 16)), 1, 0, 1'b0, "random");
        end
        run_burst(4'd0, 16, 1, 0, 1'b0, "full_len");
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter addr_width, default 1, the memory address width in bits.
REQ-002 SHALL have parameter data_width, default 1, the memory data width in bits.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state on posedge.
REQ-004 SHALL have port RST_N, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port CMD_START, input, addr_width, the first address of a burst.
REQ-006 SHALL have port CMD_LEN, input, addr_width+1, the word count of a burst; 0 is legal.
REQ-007 SHALL have port CMD_EN, input, 1, the command strobe; legal only while CMD_RDY=1.
REQ-008 SHALL have port CMD_RDY, output, 1, high only in IDLE.
REQ-009 SHALL have port MEM_RD_ADDR, output, addr_width, the read request address.
REQ-010 SHALL have port MEM_RD_EN, output, 1, the read request strobe.
REQ-011 SHALL have port MEM_RD_RDY, input, 1, the memory read credit available.
REQ-012 SHALL have port MEM_DOUT, input, data_width, the memory response data.
REQ-013 SHALL have port MEM_DOUT_RDY, input, 1, the memory response valid.
REQ-014 SHALL have port MEM_DOUT_EN, output, 1, the memory response dequeue.
REQ-015 SHALL have port OUT_DATA, output, data_width, the stream word.
REQ-016 SHALL have port OUT_LAST, output, 1, marks the final word of a burst.
REQ-017 SHALL have port OUT_RDY, output, 1, the stream word valid.
REQ-018 SHALL have port OUT_EN, input, 1, the consumer dequeue; legal only while OUT_RDY=1.
REQ-019 SHALL have port DONE, output, 1, a one-cycle completion pulse.

Function
REQ-020 SHALL implement FSM IDLE/ISSUE/DRAIN.
- IDLE on CMD_EN: latch addr=CMD_START, iss_left=rcv_left=CMD_LEN.
- If CMD_LEN=0: DONE=1 next cycle, stay IDLE.
- Otherwise go to ISSUE.
REQ-021 In ISSUE, SHALL drive MEM_RD_EN=MEM_RD_RDY combinationally, with MEM_RD_ADDR=addr.
REQ-022 On each request, SHALL increment addr modulo 2^addr_width (wrap, no error) and decrement iss_left; when iss_left reaches 0, go to DRAIN.
REQ-023 SHALL hold a one-entry output register (OUT_DATA/OUT_LAST/OUT_RDY).
- MEM_DOUT_EN = MEM_DOUT_RDY & busy & (!OUT_RDY | OUT_EN).
- On MEM_DOUT_EN: load MEM_DOUT, set OUT_LAST=(rcv_left==1), decrement rcv_left.
- Latency: word visible on OUT_* the cycle after MEM_DOUT_EN.
REQ-024 Simultaneous OUT_EN and load SHALL replace the word with no bubble; OUT_EN alone SHALL clear OUT_RDY.
REQ-025 Responses SHALL be accepted in both ISSUE and DRAIN; issue and receive SHALL overlap.
REQ-026 DRAIN SHALL exit to IDLE when rcv_left=0 and the OUT_LAST word is dequeued.
- DONE pulses in the cycle after that dequeue; CMD_RDY=1 the same cycle.
REQ-027 SHALL never assert MEM_DOUT_EN outside ISSUE/DRAIN; SHALL never assert MEM_RD_EN outside ISSUE.
REQ-028 CMD_EN while CMD_RDY=0 SHALL be ignored.

Reset
REQ-029 On RST_N low, SHALL immediately (asynchronously) enter IDLE.
- OUT_RDY=0, OUT_LAST=0, OUT_DATA=0, DONE=0, counters=0, addr=0.
- MEM_RD_EN=0, MEM_DOUT_EN=0, CMD_RDY=1.
REQ-030 Reset mid-burst SHALL abandon the burst; stale memory responses are the memory's responsibility (memory reset together).

Structure
REQ-031 SHALL place the FSM state encoding (2-bit) in the shared package; widths stay parameters.
REQ-032 SHALL have no sub-module; the output register is inline.

Verification
REQ-033 Bench SHALL pair the block with the BRAM model (2-credit read port) preloaded arr[i]=i+0x100 and cover:
- START=4, LEN=8, OUT_EN tied 1 -> data 0x104..0x10B in order, OUT_LAST on 0x10B only, DONE once.
- LEN=0 -> no MEM_RD_EN, DONE one cycle after CMD_EN, CMD_RDY stays 1.
- addr_width=4, START=14, LEN=4 -> addresses 14,15,0,1; data 0x10E,0x10F,0x100,0x101.
- OUT_EN low for 10 cycles mid-burst -> at most 2 outstanding requests, no word lost or duplicated.
- RST_N low for 1 cycle after 3 words of an LEN=8 burst -> all outputs at reset values during reset; a new LEN=2 burst then completes correctly.
- CMD_EN pulsed in ISSUE -> ignored; the original burst completes unchanged.
